versatile_mem_ctrl_wb_master: RTL and testbench
===============================================

# versatile_mem_ctrl_wb_master

Wishbone B3 burst initiator that drives one Wishbone port of the memory controller. It packs CTI/BTE/WE into the low bits of the 36-bit address word and SEL into the low bits of the 36-bit data word, matching the controller's slave-side packing. It accepts block commands (start address, length, burst type, direction), streams write data in, returns read data out, and aborts on an ack timeout. It serves as the bus-side engine for DMA/test traffic generators in the same design.

## Interface
- `timeout`, 255: number of consecutive stb-high cycles without ack before the cycle is aborted; 8-bit counter.
- `max_len`, 16: maximum beats per command; `cmd_len` is 5 bits.
- `wb_clk` in 1: the single clock.
- `wb_rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the command is accepted when `cmd_valid & cmd_ready`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 30: start word address.
- `cmd_len` in 5: beats, 1..16. A value of 0 is treated as 1.
- `cmd_bte` in 2: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `cmd_sel` in 4: byte selects applied to every beat.
- `wr_data` in 32: write data.
- `wr_valid` in 1 / `wr_ready` out 1: write data handshake.
- `rd_data` out 32: read data, equal to `wb_dat_i`.
- `rd_valid` out 1: read beat strobe.
- `done_o` out 1: one-cycle pulse at the end of a command.
- `err_o` out 1: one-cycle pulse, coincident with `done_o`, when the command was aborted.
- `wb_adr_o` out 36: address word, packed as {adr[29:0], we, bte[1:0], cti[2:0]}.
- `wb_dat_o` out 36: data word, packed as {data[31:0], sel[3:0]}.
- `wb_cyc_o` out 1 / `wb_stb_o` out 1: Wishbone cycle and strobe.
- `wb_dat_i` in 32 / `wb_ack_i` in 1: Wishbone read data and acknowledge.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept, latch we, adr, len, bte, sel; clear the beat counters and the timeout counter; go to RUN.
- **RUN**
  - `wb_cyc_o` = 1.
  - `wb_stb_o` = 1 for reads. For writes, `wb_stb_o` equals the hold-register-valid flag.
  - `ack_cnt` counts acks. `req_cnt` counts write words taken in.
- **Write data path**
  - A single hold register feeds `wb_dat_o[35:4]`.
  - `wr_ready` = RUN & we & (req_cnt < len) & (!hold_valid | wb_ack_i).
  - The hold register loads on `wr_valid & wr_ready` and clears on an ack with no reload.
- **Read data path**
  - `rd_valid` = RUN & !we & `wb_ack_i`.
  - `rd_data` = `wb_dat_i`, combinational passthrough.
- **CTI**
  - len = 1: 000 (classic).
  - Otherwise: 010 on every beat except the last, and 111 on the last beat (ack_cnt = len-1).
- **BTE field:** carries the latched bte for len > 1; 00 when classic.
- **Address advance on each ack**
  - linear: adr+1.
  - wrap4 / wrap8 / wrap16: increment only the low 2/3/4 bits modulo 4/8/16; the upper bits are held.
  - A command longer than its wrap size keeps wrapping.
  - Address arithmetic is 30-bit and wraps past 0x3FFFFFFF to 0.
- **Completion:** an ack with ack_cnt = len-1 moves the FSM to DONE.
- **Timeout**
  - The counter increments on each cycle with stb & !ack and resets on ack.
  - While stb is low for a write data wait, the counter is held.
  - Reaching `timeout` moves the FSM to DONE with the err flag set.
- **DONE**
  - cyc, stb, and `cmd_ready` are 0.
  - `done_o` = 1, and `err_o` = 1 if the command was aborted.
  - Next state is IDLE.
- **Reset mid-operation:** all registers clear asynchronously; cyc/stb drop immediately; no `done_o` is generated.

## Timing
- **Reset values:** `cmd_ready` = 1; `wb_cyc_o`, `wb_stb_o`, `wr_ready`, `rd_valid`, `done_o`, `err_o` = 0; `wb_adr_o` = 0; `wb_dat_o` = 0.
- **Read start:** accept at cycle T gives cyc/stb with the first address at T+1.
- **Write start:** the first stb comes 1 cycle after the first data is loaded (T+2 at the earliest).
- **Address change:** the address/CTI for the next beat is valid the cycle after the ack.
- **Throughput:** with zero-wait-state acks, 1 beat/cycle for both reads and writes.
- **Completion:** `done_o` is high the cycle after the final ack. The next command is accepted the cycle after that, so there is a minimum 2-cycle bus-idle gap between commands.
- **Abort:** a timeout aborts `timeout`+1 cycles after the stall begins. cyc drops in the DONE cycle.
- **Ack outside a beat:** an ack while stb = 0 is ignored.

## Test plan
- **Single read.** Read, adr 0x100, len 1, ack at T+3.
  - Expect `wb_adr_o` = {0x100, 0, 00, 000}.
  - Expect `rd_valid` with `rd_data` = ack data.
  - Expect `done_o` at T+4.
- **Linear write burst.** Write, len 4, sel F, data A0..A3, zero-wait acks.
  - Expect adr 0x200..0x203 with CTI 010, 010, 010, 111.
  - Expect `wb_dat_o[35:4]` = A0..A3 in order.
  - Expect exactly 4 `wr_ready` handshakes.
- **Wrap read.** wrap8 read, adr 0x10D, len 8.
  - Expect address sequence 0x10D, 0x10E, 0x10F, 0x108, 0x109, 0x10A, 0x10B, 0x10C.
  - Expect BTE = 10 on every beat.
- **Write data stall.** Withhold `wr_valid` for 5 cycles mid-burst.
  - Expect stb low during the gap and cyc held high.
  - Expect no timeout.
  - Expect the burst to complete correctly.
- **Timeout.** Never assert `wb_ack_i`, with `timeout` = 8.
  - Expect cyc to drop after 9 stall cycles.
  - Expect `done_o` and `err_o` pulsed together.
  - Expect the next command accepted.
- **Reset mid-burst.** Assert `wb_rst` low during beat 2 of a len-4 read.
  - Expect cyc/stb low immediately.
  - Expect no `done_o`.
  - Expect `cmd_ready` = 1 after release.

Source files
------------

// File: rtl/versatile_mem_ctrl_wb_master.sv
// Wishbone B3 burst initiator for one controller port. It executes block read/write commands and
// packs CTI/BTE/WE into the address word and SEL into the data word.
module versatile_mem_ctrl_wb_master #(
    parameter int unsigned timeout = 255,
    parameter int unsigned max_len = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [29:0] cmd_adr,
    input  logic [4:0]  cmd_len,
    input  logic [1:0]  cmd_bte,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done_o,
    output logic        err_o,
    output logic [35:0] wb_adr_o,
    output logic [35:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] TMO_LIM = 8'(timeout);
    localparam logic [4:0] MAX_LEN = 5'(max_len);

    state_t      state_q;
    logic        we_q, hold_valid_q, err_q;
    logic [29:0] adr_q;
    logic [4:0]  len_q, ack_cnt_q, req_cnt_q;
    logic [1:0]  bte_q;
    logic [3:0]  sel_q;
    logic [31:0] hold_q;
    logic [7:0]  tmo_q;

    logic        run, ack, last, wr_take;
    logic [2:0]  cti;
    logic [1:0]  bte_f;
    logic [4:0]  len_eff;

    // Handshakes: cmd, wr and the bus beat each transfer exactly on a cycle where
    // valid and ready (stb and ack) are both high at the rising clock edge.
    assign run      = (state_q == RUN);
    assign wb_cyc_o = run;
    assign wb_stb_o = run & (we_q ? hold_valid_q : 1'b1);
    assign ack      = wb_stb_o & wb_ack_i;
    assign last     = (ack_cnt_q == len_q - 5'd1);
    assign wr_ready = run & we_q & (req_cnt_q < len_q) & (~hold_valid_q | wb_ack_i);
    assign wr_take  = wr_valid & wr_ready;
    assign rd_valid = run & ~we_q & wb_ack_i;
    assign rd_data  = wb_dat_i;
    assign cmd_ready = (state_q == IDLE);
    assign done_o   = (state_q == DONE);
    assign err_o    = (state_q == DONE) & err_q;
    assign state_o  = state_q;

    assign cti      = (len_q == 5'd1) ? 3'b000 : (last ? 3'b111 : 3'b010);
    assign bte_f    = (len_q == 5'd1) ? 2'b00 : bte_q;
    assign wb_adr_o = wb_cyc_o ? {adr_q, we_q, bte_f, cti} : 36'd0;
    assign wb_dat_o = wb_cyc_o ? {hold_q, sel_q} : 36'd0;

    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == 5'd0) len_eff = 5'd1;
        else if (cmd_len > MAX_LEN) len_eff = MAX_LEN;
    end

    // Wrapping bursts only advance the low bits; the block base stays fixed.
    function automatic logic [29:0] next_adr(input logic [29:0] a, input logic [1:0] b);
        logic [29:0] n;
        n = a + 30'd1;
        case (b)
            2'b01:   n = {a[29:2], a[1:0] + 2'd1};
            2'b10:   n = {a[29:3], a[2:0] + 3'd1};
            2'b11:   n = {a[29:4], a[3:0] + 4'd1};
            default: n = a + 30'd1;
        endcase
        return n;
    endfunction

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            hold_valid_q <= 1'b0;
            err_q        <= 1'b0;
            adr_q        <= '0;
            len_q        <= '0;
            ack_cnt_q    <= '0;
            req_cnt_q    <= '0;
            bte_q        <= '0;
            sel_q        <= '0;
            hold_q       <= '0;
            tmo_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (cmd_valid) begin
                        we_q         <= cmd_we;
                        adr_q        <= cmd_adr;
                        len_q        <= len_eff;
                        bte_q        <= cmd_bte;
                        sel_q        <= cmd_sel;
                        ack_cnt_q    <= '0;
                        req_cnt_q    <= '0;
                        tmo_q        <= '0;
                        hold_valid_q <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (wr_take) begin
                        hold_q       <= wr_data;
                        hold_valid_q <= 1'b1;
                        req_cnt_q    <= req_cnt_q + 5'd1;
                    end else if (ack) begin
                        hold_valid_q <= 1'b0;
                    end
                    // Timeout only runs while a beat is actually offered to the slave.
                    if (ack) begin
                        ack_cnt_q <= ack_cnt_q + 5'd1;
                        adr_q     <= next_adr(adr_q, bte_q);
                        tmo_q     <= '0;
                        if (last) state_q <= DONE;
                    end else if (wb_stb_o) begin
                        if (tmo_q == TMO_LIM) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_versatile_mem_ctrl_wb_master.sv
// Directed bench for versatile_mem_ctrl_wb_master: vector table of bursts with hand-computed
// address sequences, plus hand sequences for latency, timeout and reset.
module tb_versatile_mem_ctrl_wb_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [29:0] cmd_adr = '0;
    logic [4:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done_o, err_o;
    logic [35:0] wb_adr_o, wb_dat_o;
    logic        wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    versatile_mem_ctrl_wb_master #(.timeout(8), .max_len(16)) dut (
        .wb_clk(clk), .wb_rst(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [4:0]  len;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic [4:0]  beats;
        logic [4:0]  gap_at;
        logic [4:0]  gap_len;
        logic [4:0]  exp_idle;
    } vec_t;

    localparam int NV = 9;
    vec_t        vecs [NV];
    logic [29:0] exp_adr [NV][8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] exp_word(input int k, input int b);
        logic [2:0] cti;
        logic [1:0] bte;
        int n;
        n   = int'(vecs[k].beats);
        bte = (n > 1) ? vecs[k].bte : 2'b00;
        cti = (n == 1) ? 3'b000 : ((b == n - 1) ? 3'b111 : 3'b010);
        return {exp_adr[k][b], vecs[k].we, bte, cti};
    endfunction

    task automatic issue_cmd(input logic we, input logic [29:0] adr, input logic [4:0] len,
                             input logic [1:0] bte, input logic [3:0] sel);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte; cmd_sel = sel;
        #1 check("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int beat, wcnt, hs, idle, cyc_n, gap_left;
        logic seen_done;
        v = vecs[k];
        beat = 0; wcnt = 0; hs = 0; idle = 0; cyc_n = 0; seen_done = 1'b0;
        gap_left = int'(v.gap_len);
        issue_cmd(v.we, v.adr, v.len, v.bte, v.sel);
        while (!seen_done && cyc_n < 60) begin
            wb_ack_i = 1'b0;
            if (v.we && wcnt == int'(v.gap_at) && gap_left > 0) begin
                wr_valid = 1'b0;
                gap_left--;
            end else begin
                wr_valid = v.we && (wcnt < int'(v.beats));
            end
            wr_data = 32'(32'hA0 + k * 256 + wcnt);
            #1;
            if (done_o) begin
                seen_done = 1'b1;
                check("end_beats", 64'(beat), 64'(v.beats));
                check("end_err", 64'(err_o), 64'd0);
                check("cyc_in_done", 64'(wb_cyc_o), 64'd0);
            end else begin
                check("cyc_in_run", 64'(wb_cyc_o), 64'd1);
                if (wb_stb_o) begin
                    if (beat < 8) check("beat_adr", 64'(wb_adr_o), 64'(exp_word(k, beat)));
                    if (v.we) check("beat_wdat", 64'(wb_dat_o), 64'({32'(32'hA0 + k * 256 + beat), v.sel}));
                    wb_dat_i = 32'(32'hC0DE_0000 + beat);
                    wb_ack_i = 1'b1;
                    #1;
                    if (!v.we) begin
                        check("rd_valid", 64'(rd_valid), 64'd1);
                        check("rd_data", 64'(rd_data), 64'(32'(32'hC0DE_0000 + beat)));
                    end
                    beat++;
                end else begin
                    if (!v.we) check("read_stb", 64'(wb_stb_o), 64'd1);
                    if (beat > 0) idle++;
                    wb_ack_i = 1'b1;
                    #1;
                end
                if (wr_valid && wr_ready) begin
                    wcnt++;
                    hs++;
                end
            end
            @(negedge clk);
            cyc_n++;
        end
        wb_ack_i = 1'b0;
        wr_valid = 1'b0;
        check("done_seen", 64'(seen_done), 64'd1);
        check("wr_handshakes", 64'(hs), v.we ? 64'(v.beats) : 64'd0);
        check("stb_idle_cycles", 64'(idle), 64'(v.exp_idle));
    endtask

    initial begin
        int n;
        int dones;

        vecs[0] = '{we:1'b0, adr:30'h100, len:5'd1, bte:2'd0, sel:4'hF, beats:5'd1, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[0] = '{30'h100, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[1] = '{we:1'b0, adr:30'h10D, len:5'd8, bte:2'd2, sel:4'hF, beats:5'd8, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[1] = '{30'h10D, 30'h10E, 30'h10F, 30'h108, 30'h109, 30'h10A, 30'h10B, 30'h10C};
        vecs[2] = '{we:1'b0, adr:30'h3FFFFFFE, len:5'd4, bte:2'd0, sel:4'hF, beats:5'd4, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[2] = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h0, 30'h1, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[3] = '{we:1'b0, adr:30'h2A, len:5'd6, bte:2'd1, sel:4'hF, beats:5'd6, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[3] = '{30'h2A, 30'h2B, 30'h28, 30'h29, 30'h2A, 30'h2B, 30'h0, 30'h0};
        vecs[4] = '{we:1'b0, adr:30'h5F, len:5'd3, bte:2'd3, sel:4'hF, beats:5'd3, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[4] = '{30'h5F, 30'h50, 30'h51, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[5] = '{we:1'b0, adr:30'h7, len:5'd0, bte:2'd2, sel:4'hF, beats:5'd1, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[5] = '{30'h7, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[6] = '{we:1'b1, adr:30'h200, len:5'd4, bte:2'd0, sel:4'hF, beats:5'd4, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[6] = '{30'h200, 30'h201, 30'h202, 30'h203, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[7] = '{we:1'b1, adr:30'h300, len:5'd4, bte:2'd1, sel:4'h3, beats:5'd4, gap_at:5'd2, gap_len:5'd5, exp_idle:5'd5};
        exp_adr[7] = '{30'h300, 30'h301, 30'h302, 30'h303, 30'h0, 30'h0, 30'h0, 30'h0};
        vecs[8] = '{we:1'b1, adr:30'h1E, len:5'd2, bte:2'd1, sel:4'h5, beats:5'd2, gap_at:5'd0, gap_len:5'd0, exp_idle:5'd0};
        exp_adr[8] = '{30'h1E, 30'h1F, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0, 30'h0};

        // Reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read, ack delayed to T+3, done at T+4
        issue_cmd(1'b0, 30'h100, 5'd1, 2'd0, 4'hF);
        #1;
        check("sr_stb_t1", 64'(wb_stb_o), 64'd1);
        check("sr_adr_t1", 64'(wb_adr_o), 64'({30'h100, 1'b0, 2'b00, 3'b000}));
        check("sr_rdv_noack", 64'(rd_valid), 64'd0);
        @(negedge clk);
        #1 check("sr_stb_t2", 64'(wb_stb_o), 64'd1);
        @(negedge clk);
        wb_dat_i = 32'h1234_5678;
        wb_ack_i = 1'b1;
        #1;
        check("sr_rdv_t3", 64'(rd_valid), 64'd1);
        check("sr_rdata_t3", 64'(rd_data), 64'h1234_5678);
        check("sr_done_t3", 64'(done_o), 64'd0);
        @(negedge clk);
        wb_ack_i = 1'b0;
        #1;
        check("sr_done_t4", 64'(done_o), 64'd1);
        check("sr_err_t4", 64'(err_o), 64'd0);
        check("sr_cyc_t4", 64'(wb_cyc_o), 64'd0);
        check("sr_ready_t4", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        #1;
        check("sr_ready_t5", 64'(cmd_ready), 64'd1);
        check("sr_done_t5", 64'(done_o), 64'd0);

        for (int k = 0; k < NV; k++) run_vec(k);

        // Timeout: no ack ever, limit 8 -> 9 stalled cycles, then done+err together
        issue_cmd(1'b0, 30'h40, 5'd4, 2'd0, 4'hF);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (done_o) break;
            if (wb_cyc_o) n++;
            @(negedge clk);
        end
        check("tmo_done", 64'(done_o), 64'd1);
        check("tmo_err", 64'(err_o), 64'd1);
        check("tmo_cyc_low", 64'(wb_cyc_o), 64'd0);
        check("tmo_stall_cycles", 64'(n), 64'd9);
        @(negedge clk);
        #1 check("tmo_ready_after", 64'(cmd_ready), 64'd1);
        run_vec(4);

        // Reset during beat 2 of a len-4 read
        issue_cmd(1'b0, 30'h80, 5'd4, 2'd0, 4'hF);
        wb_ack_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wb_ack_i = 1'b0;
        #1;
        check("mid_stb_beat2", 64'(wb_stb_o), 64'd1);
        check("mid_adr_beat2", 64'(wb_adr_o), 64'({30'h82, 1'b0, 2'b00, 3'b010}));
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("mid_rst_stb", 64'(wb_stb_o), 64'd0);
        check("mid_rst_adr", 64'(wb_adr_o), 64'd0);
        dones = 0;
        @(negedge clk);
        if (done_o) dones++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (done_o) dones++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 64'(dones), 64'd0);
        #1 check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        run_vec(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule
